// File: rtl/line_fill_memory_if.sv
// Bundle of the line-refill requester ports, preload port and busy flag.
// The memory drives the slave side; the caches/bench drive the master side.
interface line_fill_memory_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LINE_BYTES = 16
);
  logic                    req0;
  logic [ADDR_WIDTH-1:0]   addr0;
  logic                    gnt0;
  logic                    rvalid0;
  logic [LINE_BYTES*8-1:0] rdata0;

  logic                    req1;
  logic [ADDR_WIDTH-1:0]   addr1;
  logic                    gnt1;
  logic                    rvalid1;
  logic [LINE_BYTES*8-1:0] rdata1;

  logic                    pl_we;
  logic [ADDR_WIDTH-1:0]   pl_addr;
  logic [LINE_BYTES*8-1:0] pl_wdata;

  logic                    busy;

  modport master (
    output req0, addr0, req1, addr1, pl_we, pl_addr, pl_wdata,
    input  gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1, busy
  );

  modport slave (
    input  req0, addr0, req1, addr1, pl_we, pl_addr, pl_wdata,
    output gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1, busy
  );
endinterface

// File: rtl/line_fill_memory.sv
// Two-port line-refill memory responder: round-robin grant, one transaction in flight,
// fixed latency from grant to a one-cycle rvalid carrying the grant-time line snapshot.
module line_fill_memory #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LINE_BYTES = 16,
  parameter int unsigned MEM_BYTES  = 4096,
  parameter int unsigned LATENCY    = 4
) (
  input logic               clk,
  input logic               rstn,
  line_fill_memory_if.slave bus
);

  localparam int unsigned OFFSET_BITS = $clog2(LINE_BYTES);
  localparam int unsigned MEM_LINES   = MEM_BYTES / LINE_BYTES;
  localparam int unsigned IDX_BITS    = $clog2(MEM_LINES);
  localparam int unsigned DATA_W      = LINE_BYTES * 8;
  localparam int unsigned CNT_W       = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                port_q, port_d;
  logic                rr_last_q, rr_last_d;
  logic [DATA_W-1:0]   line_q, line_d;
  logic                rvalid0_q, rvalid1_q;
  logic                rvalid0_d, rvalid1_d;
  logic [DATA_W-1:0]   rdata0_q, rdata1_q;
  logic                gnt0, gnt1;

  logic [IDX_BITS-1:0] idx0, idx1, pl_idx;
  logic [DATA_W-1:0]   mem [MEM_LINES];

  // Upper address bits are dropped, so addresses alias onto the array.
  assign idx0   = bus.addr0[OFFSET_BITS +: IDX_BITS];
  assign idx1   = bus.addr1[OFFSET_BITS +: IDX_BITS];
  assign pl_idx = bus.pl_addr[OFFSET_BITS +: IDX_BITS];

  // Backing array is deliberately not reset; the preload port initialises it.
  always_ff @(posedge clk) begin
    if (bus.pl_we) begin
      mem[pl_idx] <= bus.pl_wdata;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      port_q    <= 1'b0;
      rr_last_q <= 1'b1;
      line_q    <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      port_q    <= port_d;
      rr_last_q <= rr_last_d;
      line_q    <= line_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      if (rvalid0_d) rdata0_q <= line_d;
      if (rvalid1_d) rdata1_q <= line_d;
    end
  end

  // Snapshot is taken from the pre-edge array, so a same-edge preload is not seen.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    port_d    = port_q;
    rr_last_d = rr_last_q;
    line_d    = line_q;
    unique case (state_q)
      StIdle: begin
        if (gnt0 || gnt1) begin
          state_d   = (LATENCY == 1) ? StResp : StWait;
          cnt_d     = CNT_W'(LATENCY - 1);
          port_d    = gnt1;
          rr_last_d = gnt1;
          line_d    = gnt1 ? mem[idx1] : mem[idx0];
        end
      end
      StWait: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = StResp;
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rstn && (state_q == StIdle)) begin
      gnt0 = bus.req0 && (!bus.req1 || rr_last_q);
      gnt1 = bus.req1 && !gnt0;
    end
    rvalid0_d = (state_d == StResp) && !port_d;
    rvalid1_d = (state_d == StResp) && port_d;
  end

  assign bus.gnt0    = gnt0;
  assign bus.gnt1    = gnt1;
  assign bus.rvalid0 = rvalid0_q;
  assign bus.rvalid1 = rvalid1_q;
  assign bus.rdata0  = rdata0_q;
  assign bus.rdata1  = rdata1_q;
  assign bus.busy    = (state_q != StIdle);

endmodule

// File: tb/tb_line_fill_memory.sv
// Bench for line_fill_memory: directed scenarios plus random traffic checked against
// a transaction-level model (grant times, response times, line snapshots).
module tb_line_fill_memory;
  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned LINE_BYTES = 16;
  localparam int unsigned MEM_BYTES  = 4096;
  localparam int unsigned LATENCY    = 4;
  localparam int unsigned DW         = LINE_BYTES * 8;
  localparam int unsigned MEM_LINES  = MEM_BYTES / LINE_BYTES;
  localparam logic [DW-1:0] LINE3 = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
  localparam logic [DW-1:0] NEW3  = 128'h11112222_33334444_55556666_77778888;
  localparam logic [ADDR_WIDTH-1:0] A0 = '0;
  localparam logic [DW-1:0] D0 = '0;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  line_fill_memory_if #(.ADDR_WIDTH(ADDR_WIDTH), .LINE_BYTES(LINE_BYTES)) bus ();

  line_fill_memory #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .LINE_BYTES(LINE_BYTES),
    .MEM_BYTES (MEM_BYTES),
    .LATENCY   (LATENCY)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Transaction-level model state.
  logic [DW-1:0] m_mem [MEM_LINES];
  logic [DW-1:0] m_last [2];
  logic          m_pending = 1'b0;
  logic          m_in_reset = 1'b1;
  int            m_resp_at = 0;
  int            m_resp_port = 0;
  logic [DW-1:0] m_resp_data = '0;
  int            m_rr_last = 1;

  function automatic int line_of(input logic [ADDR_WIDTH-1:0] a);
    return int'((a / LINE_BYTES) % MEM_LINES);
  endfunction

  // Expected {gnt0, gnt1, rvalid0, rvalid1, busy} for the current cycle and inputs.
  function automatic logic [4:0] model_out();
    logic idle, g0, g1, rv0, rv1;
    idle = !m_in_reset && !m_pending;
    g0   = idle && bus.req0 && (!bus.req1 || m_rr_last == 1);
    g1   = idle && bus.req1 && !g0;
    rv0  = m_pending && (cyc == m_resp_at) && (m_resp_port == 0);
    rv1  = m_pending && (cyc == m_resp_at) && (m_resp_port == 1);
    return {g0, g1, rv0, rv1, m_pending};
  endfunction

  function automatic logic [4:0] observed();
    return {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.busy};
  endfunction

  task automatic model_reset();
    m_pending = 1'b0;
    m_rr_last = 1;
    m_last[0] = '0;
    m_last[1] = '0;
  endtask

  task automatic drive(input logic r0, input logic [ADDR_WIDTH-1:0] a0,
                       input logic r1, input logic [ADDR_WIDTH-1:0] a1,
                       input logic we, input logic [ADDR_WIDTH-1:0] pa,
                       input logic [DW-1:0] pd);
    bus.req0     = r0;
    bus.addr0    = a0;
    bus.req1     = r1;
    bus.addr1    = a1;
    bus.pl_we    = we;
    bus.pl_addr  = pa;
    bus.pl_wdata = pd;
    #1;
  endtask

  // Advance one clock and apply that edge's effects to the model.
  task automatic tick();
    logic [4:0] e;
    e = model_out();
    @(posedge clk);
    if (m_pending && cyc == m_resp_at) begin
      m_pending = 1'b0;
    end else if (e[4] || e[3]) begin
      m_pending   = 1'b1;
      m_resp_at   = cyc + int'(LATENCY);
      m_resp_port = e[4] ? 0 : 1;
      m_resp_data = m_mem[line_of(e[4] ? bus.addr0 : bus.addr1)];
      m_rr_last   = m_resp_port;
    end
    if (m_pending && cyc + 1 == m_resp_at) m_last[m_resp_port] = m_resp_data;
    if (bus.pl_we) m_mem[line_of(bus.pl_addr)] = bus.pl_wdata;
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, A0, 1'b0, A0, 1'b0, A0, D0);
    rstn = 1'b0;
    m_in_reset = 1'b1;
    model_reset();
    tick();
    tick();
    rstn = 1'b1;
    m_in_reset = 1'b0;
  endtask

  task automatic idle_until_free();
    for (int c = 0; c < 2 * int'(LATENCY) + 4 && m_pending; c++) begin
      drive(1'b0, A0, 1'b0, A0, 1'b0, A0, D0);
      tick();
    end
  endtask

  task automatic test_reset();
    drive(1'b1, 32'h34, 1'b1, 32'h50, 1'b0, A0, D0);
    rstn = 1'b0;
    m_in_reset = 1'b1;
    model_reset();
    tick();
    checks++;
    if (observed() !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctl got=%b want=00000", observed());
    end
    checks++;
    if (bus.rdata0 !== D0 || bus.rdata1 !== D0) begin
      failures++;
      $display("FAIL reset_rdata got=%h/%h want=0/0", bus.rdata0, bus.rdata1);
    end
    drive(1'b0, A0, 1'b0, A0, 1'b0, A0, D0);
    tick();
    rstn = 1'b1;
    m_in_reset = 1'b0;
  endtask

  task automatic init_mem();
    for (int i = 0; i < int'(MEM_LINES); i++) begin
      drive(1'b0, A0, 1'b0, A0, 1'b1, ADDR_WIDTH'(i * int'(LINE_BYTES)),
            {$urandom(), $urandom(), $urandom(), $urandom()});
      tick();
    end
    drive(1'b0, A0, 1'b0, A0, 1'b1, 32'h30, LINE3);
    tick();
  endtask

  task automatic test_basic();
    drive(1'b1, 32'h34, 1'b0, A0, 1'b0, A0, D0);
    checks++;
    if (bus.gnt0 !== 1'b1) begin
      failures++;
      $display("FAIL basic_gnt got=%b want=1", bus.gnt0);
    end
    tick();
    for (int k = 1; k <= 6; k++) begin
      drive(1'b0, A0, 1'b0, A0, 1'b0, A0, D0);
      checks++;
      if (bus.rvalid0 !== (k == int'(LATENCY)) || bus.rvalid1 !== 1'b0) begin
        failures++;
        $display("FAIL basic_rvalid k=%0d got=%b%b want=%b0", k, bus.rvalid0, bus.rvalid1,
                 k == int'(LATENCY));
      end
      if (k == int'(LATENCY)) begin
        checks++;
        if (bus.rdata0 !== LINE3) begin
          failures++;
          $display("FAIL basic_rdata got=%h want=%h", bus.rdata0, LINE3);
        end
      end
      tick();
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    logic [ADDR_WIDTH-1:0] a0, a1;
    logic [4:0] e;
    do_reset();
    a0 = $urandom();
    a1 = $urandom();
    for (int c = 0; c < 24; c++) begin
      drive(1'b1, a0, 1'b1, a1, 1'b0, A0, D0);
      e = model_out();
      checks++;
      if (observed() !== e) begin
        failures++;
        $display("FAIL rr_ctl cycle=%0d got=%b want=%b", c, observed(), e);
      end
      checks++;
      if (bus.rdata0 !== m_last[0] || bus.rdata1 !== m_last[1]) begin
        failures++;
        $display("FAIL rr_rdata cycle=%0d got=%h/%h want=%h/%h", c, bus.rdata0, bus.rdata1,
                 m_last[0], m_last[1]);
      end
      if (bus.gnt0) order.push_back(0);
      if (bus.gnt1) order.push_back(1);
      tick();
    end
    checks++;
    if (order.size() < 4 || order[0] != 0 || order[1] != 1 || order[2] != 0 || order[3] != 1)
    begin
      failures++;
      $display("FAIL rr_order got=%p want=0,1,0,1,...", order);
    end
  endtask

  task automatic test_alias();
    bit got = 1'b0;
    idle_until_free();
    drive(1'b0, A0, 1'b1, 32'h1034, 1'b0, A0, D0);
    checks++;
    if (bus.gnt1 !== 1'b1) begin
      failures++;
      $display("FAIL alias_gnt got=%b want=1", bus.gnt1);
    end
    tick();
    for (int c = 1; c <= int'(LATENCY) + 2; c++) begin
      drive(1'b0, A0, 1'b0, A0, 1'b0, A0, D0);
      if (bus.rvalid1 === 1'b1) begin
        got = 1'b1;
        checks++;
        if (bus.rdata1 !== LINE3) begin
          failures++;
          $display("FAIL alias_rdata got=%h want=%h", bus.rdata1, LINE3);
        end
      end
      tick();
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL alias_timeout got=no_rvalid1 want=rvalid1");
    end
  endtask

  task automatic test_busy_block();
    idle_until_free();
    drive(1'b1, 32'h34, 1'b0, A0, 1'b0, A0, D0);
    checks++;
    if (bus.gnt0 !== 1'b1) begin
      failures++;
      $display("FAIL block_gnt0 got=%b want=1", bus.gnt0);
    end
    tick();
    for (int c = 1; c <= int'(LATENCY); c++) begin
      drive(1'b0, A0, c >= 2, 32'h200, 1'b0, A0, D0);
      checks++;
      if (bus.gnt1 !== 1'b0 || bus.busy !== 1'b1) begin
        failures++;
        $display("FAIL block_busy cycle=%0d got=gnt1:%b busy:%b want=gnt1:0 busy:1",
                 c, bus.gnt1, bus.busy);
      end
      if (c == int'(LATENCY)) begin
        checks++;
        if (bus.rvalid0 !== 1'b1) begin
          failures++;
          $display("FAIL block_rvalid0 got=%b want=1", bus.rvalid0);
        end
      end
      tick();
    end
    drive(1'b0, A0, 1'b1, 32'h200, 1'b0, A0, D0);
    checks++;
    if (bus.gnt1 !== 1'b1 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL block_release got=gnt1:%b busy:%b want=gnt1:1 busy:0", bus.gnt1, bus.busy);
    end
    tick();
    idle_until_free();
  endtask

  task automatic test_abandon();
    bit got = 1'b0;
    idle_until_free();
    drive(1'b1, 32'h30, 1'b0, A0, 1'b0, A0, D0);
    tick();
    for (int c = 1; c <= int'(LATENCY) + 1; c++) begin
      drive(1'b0, A0, 1'b0, A0, c == 2, 32'h30, NEW3);
      if (c == int'(LATENCY)) begin
        got = bus.rvalid0;
        checks++;
        if (bus.rvalid0 !== 1'b1 || bus.rdata0 !== LINE3) begin
          failures++;
          $display("FAIL abandon_rdata got=%b:%h want=1:%h", bus.rvalid0, bus.rdata0, LINE3);
        end
      end
      tick();
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL abandon_timeout got=no_rvalid0 want=rvalid0");
    end
  endtask

  task automatic test_same_edge();
    logic [DW-1:0] old5, new5;
    idle_until_free();
    old5 = m_mem[5];
    new5 = ~old5;
    drive(1'b1, 32'h50, 1'b0, A0, 1'b1, 32'h50, new5);
    tick();
    for (int c = 1; c <= int'(LATENCY); c++) begin
      drive(1'b0, A0, 1'b0, A0, 1'b0, A0, D0);
      if (c == int'(LATENCY)) begin
        checks++;
        if (bus.rvalid0 !== 1'b1 || bus.rdata0 !== old5) begin
          failures++;
          $display("FAIL same_edge got=%b:%h want=1:%h", bus.rvalid0, bus.rdata0, old5);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    bit got = 1'b0;
    idle_until_free();
    drive(1'b1, 32'h30, 1'b0, A0, 1'b0, A0, D0);
    tick();
    drive(1'b0, A0, 1'b0, A0, 1'b0, A0, D0);
    tick();
    drive(1'b1, 32'h30, 1'b0, A0, 1'b0, A0, D0);
    rstn = 1'b0;
    m_in_reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (observed() !== 5'b0) begin
      failures++;
      $display("FAIL reset_mid_ctl got=%b want=00000", observed());
    end
    tick();
    tick();
    rstn = 1'b1;
    m_in_reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      drive(1'b0, A0, 1'b0, A0, 1'b0, A0, D0);
      checks++;
      if (bus.rvalid0 !== 1'b0 || bus.rvalid1 !== 1'b0 || bus.busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_mid_quiet cycle=%0d got=%b%b%b want=000", c, bus.rvalid0,
                 bus.rvalid1, bus.busy);
      end
      tick();
    end
    drive(1'b1, 32'h30, 1'b0, A0, 1'b0, A0, D0);
    tick();
    for (int c = 1; c <= int'(LATENCY) + 2; c++) begin
      drive(1'b0, A0, 1'b0, A0, 1'b0, A0, D0);
      if (bus.rvalid0 === 1'b1) begin
        got = 1'b1;
        checks++;
        if (bus.rdata0 !== NEW3) begin
          failures++;
          $display("FAIL reread_rdata got=%h want=%h", bus.rdata0, NEW3);
        end
      end
      tick();
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL reread_timeout got=no_rvalid0 want=rvalid0");
    end
  endtask

  task automatic test_random();
    logic [ADDR_WIDTH-1:0] a0, a1, pa;
    logic [4:0] e;
    for (int c = 0; c < 400; c++) begin
      // Few lines, random upper/offset bits: forces collisions and aliasing.
      a0 = ($urandom() & 32'hFFFF_F00F) | (ADDR_WIDTH'($urandom_range(0, 3)) << 4);
      a1 = ($urandom() & 32'hFFFF_F00F) | (ADDR_WIDTH'($urandom_range(0, 3)) << 4);
      pa = ($urandom() & 32'hFFFF_F00F) | (ADDR_WIDTH'($urandom_range(0, 3)) << 4);
      drive($urandom_range(0, 3) != 0, a0, $urandom_range(0, 3) != 0, a1,
            $urandom_range(0, 4) == 0, pa, {$urandom(), $urandom(), $urandom(), $urandom()});
      e = model_out();
      checks++;
      if (observed() !== e) begin
        failures++;
        $display("FAIL rand_ctl cycle=%0d got=%b want=%b", c, observed(), e);
      end
      checks++;
      if (bus.rdata0 !== m_last[0] || bus.rdata1 !== m_last[1]) begin
        failures++;
        $display("FAIL rand_rdata cycle=%0d got=%h/%h want=%h/%h", c, bus.rdata0, bus.rdata1,
                 m_last[0], m_last[1]);
      end
      tick();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    init_mem();
    test_basic();
    test_round_robin();
    test_alias();
    test_busy_block();
    test_abandon();
    test_same_edge();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
